bcd_display_scan: RTL and testbench
===================================

// Module: bcd_display_scan
// PURPOSE
//   Downstream stage of the stopwatch BCD counter: time-multiplexes the two BCD
//   digits (digit_h:digit_l) onto a 2-digit common-anode 7-segment display.
//   Also flashes the whole display for a fixed time after each counter overflow
//   pulse. Sits between the counter and the board's seg/anode pins.
// PARAMETERS
//   SCAN_DIV      25000      clk cycles per digit slot (>=2)
//   FLASH_HALF    12500000   clk cycles per flash half-period (>=1)
//   FLASH_BLINKS  3          dark+lit pairs per flash sequence (>=1)
// PORTS
//   clk       in   1  system clock; all logic on posedge
//   rst_n     in   1  synchronous, active-low reset
//   digit_l   in   4  low BCD digit (0-9 legal)
//   digit_h   in   4  high BCD digit (0-9 legal)
//   overflow  in   1  one-cycle pulse from the counter on 99->00 wrap
//   seg       out  8  {dp,g,f,e,d,c,b,a}; active-low (0 = lit); registered
//   an        out  2  digit enables; active-low; an[0]=low digit; registered
//   flashing  out  1  high while a flash sequence runs; registered
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): scan_cnt=0, slot=0, flash state idle.
//   Outputs seg=8'hFF, an=2'b11, flashing=0.
// - Scan: scan_cnt counts 0..SCAN_DIV-1 and wraps.
//   - On wrap, slot toggles.
//   - slot0 selects digit_l with an=2'b10; slot1 selects digit_h with an=2'b01.
//   - an is never 2'b00.
// - Latency: seg/an are registered one cycle after slot/digit inputs change.
//   - First cycle after rst_n rises: an=2'b10 with digit_l's pattern.
// - Decode (active-high a-g, then inverted; dp is always off):
//   - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
//   - Codes 10-15 show a dash (g only, 8'hBF on seg).
//   - Example: seg for 0 = 8'hC0.
// - Flash FSM with states IDLE and RUN; a 2*FLASH_BLINKS half counter and a
//   FLASH_HALF cycle counter.
//   - IDLE: overflow=1 -> RUN with counters cleared; flashing=1 on the next cycle.
//   - RUN: even halves (starting with half 0) are dark, odd halves are lit.
//     - Dark: seg=8'hFF while an keeps scanning. Lit: normal decode.
//   - RUN: after the last cycle of the final half -> IDLE, flashing=0.
//     - Total RUN length = 2*FLASH_BLINKS*FLASH_HALF cycles.
//   - overflow=1 while in RUN restarts the sequence from half 0 (retrigger).
//     This takes priority over the end-of-sequence transition in the same cycle.
// - Reset mid-flash forces IDLE immediately; a coincident overflow is ignored.
// - Inputs digit_l, digit_h and overflow are synchronous to clk; no
//   synchronizers are used.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN
//   - Defined: in slot1, when digit_h==0, seg=8'hFF (high digit blank).
//     The low digit always shows, including "0".
//   - Undefined: the high digit is always decoded (a leading 0 is shown as 8'hC0).
//   - Flash blanking overrides both cases.
// TESTING (SCAN_DIV=4, FLASH_HALF=8, FLASH_BLINKS=2)
// 1. rst_n=0 for 3 cycles -> seg=8'hFF, an=2'b11, flashing=0.
//    Release -> next cycle an=2'b10.
// 2. digit_h=4, digit_l=2 -> slot0 seg=8'hA4, an=2'b10; 4 cycles later
//    seg=8'h99, an=2'b01. Then alternates every 4 cycles, never an=2'b00.
// 3. digit_l=4'hC -> slot0 seg=8'hBF. digit_l=9 -> 8'h90.
// 4. One-cycle overflow -> flashing=1 next cycle; seg=8'hFF for 8 cycles, then
//    normal for 8, dark 8, normal 8. flashing=0 after 32 cycles; an scans throughout.
// 5. Second overflow 20 cycles into RUN -> sequence restarts: dark 8 cycles,
//    flashing held 32 more cycles. rst_n=0 mid-RUN -> flashing=0, seg=8'hFF next cycle.
// 6. digit_h=0, digit_l=7, slot1 -> seg=8'hFF with LEADING_ZERO_BLANK_EN,
//    8'hC0 without. Slot0 -> 8'hF8 in both builds.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Two-digit common-anode 7-segment scanner with a post-overflow flash sequence.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the high digit when it is 0.
module bcd_display_scan #(
    parameter int SCAN_DIV     = 25000,
    parameter int FLASH_HALF   = 12500000,
    parameter int FLASH_BLINKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_l,
    input  logic [3:0] digit_h,
    input  logic       overflow,
    output logic [7:0] seg,
    output logic [1:0] an,
    output logic       flashing
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CYC_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int HALF_W = (2 * FLASH_BLINKS > 1) ? $clog2(2 * FLASH_BLINKS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } flash_state_e;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              slot_q, slot_d;
    flash_state_e      state_q, state_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [7:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;
    logic              flashing_q, flashing_d;

    logic scan_wrap;
    logic cyc_last;
    logic half_last;
    logic [3:0] digit_sel;

    // Active-high {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            scan_cnt_q <= '0;
            slot_q     <= 1'b0;
            state_q    <= IDLE;
            half_q     <= '0;
            cyc_q      <= '0;
            seg_q      <= 8'hFF;
            an_q       <= 2'b11;
            flashing_q <= 1'b0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            slot_q     <= slot_d;
            state_q    <= state_d;
            half_q     <= half_d;
            cyc_q      <= cyc_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            flashing_q <= flashing_d;
        end
    end

    // Next-state logic: scan divider and flash sequencer
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        slot_d     = slot_q ^ scan_wrap;
        cyc_last   = (cyc_q == CYC_W'(FLASH_HALF - 1));
        half_last  = (half_q == HALF_W'(2 * FLASH_BLINKS - 1));
        state_d    = state_q;
        half_d     = half_q;
        cyc_d      = cyc_q;

        case (state_q)
            IDLE: begin
                if (overflow) begin
                    state_d = RUN;
                    half_d  = '0;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                // A retrigger wins over the end-of-sequence exit.
                if (overflow) begin
                    half_d = '0;
                    cyc_d  = '0;
                end else if (cyc_last) begin
                    cyc_d = '0;
                    if (half_last) begin
                        state_d = IDLE;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                half_d  = '0;
                cyc_d   = '0;
            end
        endcase
    end

    // Output logic. Flash blanking follows the next flash state so the dark
    // halves line up exactly with the cycles where flashing is high.
    always_comb begin
        digit_sel  = slot_q ? digit_h : digit_l;
        seg_d      = ~{1'b0, decode(digit_sel)};
        an_d       = slot_q ? 2'b01 : 2'b10;
        flashing_d = (state_d == RUN);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot_q && (digit_h == 4'd0)) begin
            seg_d = 8'hFF;
        end
`endif
        if ((state_d == RUN) && !half_d[0]) begin
            seg_d = 8'hFF;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign flashing = flashing_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan (SCAN_DIV=4, FLASH_HALF=8, FLASH_BLINKS=2).
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the bench.
module tb_bcd_display_scan;

    localparam int SD = 4;
    localparam int FH = 8;
    localparam int FB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit_l;
    logic [3:0] digit_h;
    logic       overflow;
    logic [7:0] seg;
    logic [1:0] an;
    logic       flashing;

    int n_cmp = 0;
    int n_bad = 0;
    int n_edges = 0;

    bcd_display_scan #(
        .SCAN_DIV    (SD),
        .FLASH_HALF  (FH),
        .FLASH_BLINKS(FB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digit_l (digit_l),
        .digit_h (digit_h),
        .overflow(overflow),
        .seg     (seg),
        .an      (an),
        .flashing(flashing)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one edge; n_edges counts edges since reset was released.
    task automatic tick();
        @(posedge clk);
        if (rst_n) n_edges++;
        else n_edges = 0;
        #1;
    endtask

    // Slot visible on the outputs: first SD edges after release show slot 0.
    function automatic logic exp_slot();
        return (((n_edges - 1) / SD) % 2) != 0;
    endfunction

    // Expected visible value for digits h=4, l=2 when not dark.
    function automatic logic [7:0] seg_42();
        return exp_slot() ? 8'h99 : 8'hA4;
    endfunction

    function automatic logic [1:0] an_exp();
        return exp_slot() ? 2'b01 : 2'b10;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; overflow = 1'b0; digit_h = 4'd4; digit_l = 4'd2;
        repeat (3) tick();
        n_cmp++;
        if ({seg, an, flashing} !== {8'hFF, 2'b11, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: got seg=%h an=%b fl=%b want seg=ff an=11 fl=0", seg, an, flashing);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({seg, an, flashing} !== {8'hA4, 2'b10, 1'b0}) begin
            n_bad++;
            $display("FAIL release: got seg=%h an=%b fl=%b want seg=a4 an=10 fl=0", seg, an, flashing);
        end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 4 * SD; i++) begin
            tick();
            n_cmp++;
            if ({seg, an, flashing} !== {seg_42(), an_exp(), 1'b0} || an === 2'b00) begin
                n_bad++;
                $display("FAIL scan[%0d]: got seg=%h an=%b fl=%b want seg=%h an=%b fl=0",
                         i, seg, an, flashing, seg_42(), an_exp());
            end
        end
    endtask

    task automatic test_decode();
        logic [3:0] codes [2];
        logic [7:0] want  [2];
        codes[0] = 4'hC; want[0] = 8'hBF;
        codes[1] = 4'd9; want[1] = 8'h90;
        for (int k = 0; k < 2; k++) begin
            digit_l = codes[k];
            for (int i = 0; i < 2 * SD; i++) begin
                tick();
                if (!exp_slot()) break;
            end
            n_cmp++;
            if ({seg, an} !== {want[k], 2'b10}) begin
                n_bad++;
                $display("FAIL decode %h: got seg=%h an=%b want seg=%h an=10", codes[k], seg, an, want[k]);
            end
        end
        digit_l = 4'd2;
        tick();
    endtask

    task automatic test_flash();
        logic [7:0] want;
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        for (int i = 0; i <= 2 * FB * FH; i++) begin
            want = (i < 2 * FB * FH && ((i / FH) % 2) == 0) ? 8'hFF : seg_42();
            n_cmp++;
            if ({seg, an, flashing} !== {want, an_exp(), (i < 2 * FB * FH)}) begin
                n_bad++;
                $display("FAIL flash[%0d]: got seg=%h an=%b fl=%b want seg=%h an=%b fl=%b",
                         i, seg, an, flashing, want, an_exp(), (i < 2 * FB * FH));
            end
            if (i < 2 * FB * FH) tick();
        end
    endtask

    task automatic test_retrigger();
        logic [7:0] want;
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        for (int i = 0; i < 20; i++) begin
            want = (((i / FH) % 2) == 0) ? 8'hFF : seg_42();
            n_cmp++;
            if ({seg, an, flashing} !== {want, an_exp(), 1'b1}) begin
                n_bad++;
                $display("FAIL pre_retrig[%0d]: got seg=%h an=%b fl=%b want seg=%h an=%b fl=1",
                         i, seg, an, flashing, want, an_exp());
            end
            if (i == 19) overflow = 1'b1;
            tick();
            overflow = 1'b0;
        end
        for (int i = 0; i <= 2 * FB * FH; i++) begin
            want = (i < 2 * FB * FH && ((i / FH) % 2) == 0) ? 8'hFF : seg_42();
            n_cmp++;
            if ({seg, an, flashing} !== {want, an_exp(), (i < 2 * FB * FH)}) begin
                n_bad++;
                $display("FAIL retrig[%0d]: got seg=%h an=%b fl=%b want seg=%h an=%b fl=%b",
                         i, seg, an, flashing, want, an_exp(), (i < 2 * FB * FH));
            end
            if (i < 2 * FB * FH) tick();
        end
    endtask

    task automatic test_reset_mid_flash();
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (flashing !== 1'b1) begin
            n_bad++;
            $display("FAIL midflash_run: got fl=%b want fl=1", flashing);
        end
        rst_n = 1'b0;
        overflow = 1'b1;
        tick();
        n_cmp++;
        if ({seg, an, flashing} !== {8'hFF, 2'b11, 1'b0}) begin
            n_bad++;
            $display("FAIL midflash_reset: got seg=%h an=%b fl=%b want seg=ff an=11 fl=0", seg, an, flashing);
        end
        overflow = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({seg, an, flashing} !== {seg_42(), an_exp(), 1'b0}) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: got seg=%h an=%b fl=%b want seg=%h an=%b fl=0",
                         i, seg, an, flashing, seg_42(), an_exp());
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] want_h;
`ifdef LEADING_ZERO_BLANK_EN
        want_h = 8'hFF;
`else
        want_h = 8'hC0;
`endif
        digit_h = 4'd0;
        digit_l = 4'd7;
        for (int i = 0; i < 2 * SD; i++) begin
            tick();
            if (exp_slot()) break;
        end
        n_cmp++;
        if ({seg, an} !== {want_h, 2'b01}) begin
            n_bad++;
            $display("FAIL lz_high: got seg=%h an=%b want seg=%h an=01", seg, an, want_h);
        end
        for (int i = 0; i < 2 * SD; i++) begin
            tick();
            if (!exp_slot()) break;
        end
        n_cmp++;
        if ({seg, an} !== {8'hF8, 2'b10}) begin
            n_bad++;
            $display("FAIL lz_low: got seg=%h an=%b want seg=f8 an=10", seg, an);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_flash();
        test_retrigger();
        test_reset_mid_flash();
        test_leading_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
